mine_place_ctrl: RTL and testbench
==================================

# mine_place_ctrl

Sequencer that owns the mine-placement RNG for a new game. It configures the RNG's multiplier, increment and mine count, pulses its start, and waits for place-done with a timeout. It checks that the returned 25-cell mine map holds exactly the requested number of distinct mines. On success it publishes the map to the board logic; otherwise it retries with new LCG parameters, up to a retry limit.

## Interface
Parameters:
- TIMEOUT, 31: maximum WAIT cycles minus one before an attempt is abandoned (5-bit timer).
- MAX_RETRY, 7: retries allowed after the first attempt (3-bit counter).

Ports:
- clka  in  1  single system clock; all state updates on rising edge.
- restart  in  1  reset, asynchronous and active-high.
- new_game  in  1  request to place a fresh board; sampled only in IDLE, DONE, FAIL.
- difficulty  in  2  mine-count select: 0→2, 1→3, 2→5, 3→7 mines.
- seed  in  3  base multiplier for attempt 0.
- rng_start  out  1  one-cycle start pulse to RNG.
- rng_mult  out  3  LCG multiplier 'a' driven to RNG.
- rng_incr  out  3  LCG increment 'c' driven to RNG.
- rng_n_mines  out  3  mine count driven to RNG.
- rng_place_done  in  1  RNG completion flag.
- rng_mines  in  25  RNG mine map, valid when rng_place_done=1.
- board  out  25  accepted mine map.
- mine_count  out  3  mines in board (equals rng_n_mines on success).
- board_valid  out  1  board accepted and stable.
- busy  out  1  high in CONFIG, START, WAIT, CHECK.
- error  out  1  placement failed after all retries.
- retries  out  3  retries consumed in current/last request.

## Operation
- States: IDLE, CONFIG, START, WAIT, CHECK, DONE, FAIL. Reset → IDLE, every output 0, timer 0.
- IDLE/DONE/FAIL + new_game=1 → CONFIG:
  - latch difficulty into rng_n_mines;
  - clear retries, board_valid, error;
  - board keeps its old value until the next success.
- CONFIG (1 cycle):
  - rng_mult = seed + retries (3-bit wrap);
  - rng_incr = 2·retries + 1 (3-bit wrap, always odd);
  - → START.
- START (1 cycle): rng_start=1; timer cleared; → WAIT. rng_start is 0 in every other state.
- WAIT:
  - rng_place_done=1 → capture rng_mines into a staging register, → CHECK;
  - otherwise, if timer==TIMEOUT → CHECK with failure forced;
  - otherwise timer+1;
  - place_done wins if it coincides with timeout.
- CHECK (1 cycle): 5-bit popcount of staging register compared with zero-extended rng_n_mines.
  - Match → board=staging, mine_count=rng_n_mines, → DONE.
  - Mismatch or timeout, retries<MAX_RETRY → retries+1, → CONFIG.
  - Mismatch or timeout, retries==MAX_RETRY → FAIL.
- DONE: board_valid=1, held until new_game or restart.
- FAIL: error=1, board_valid=0, held until new_game or restart.
- new_game during busy is ignored, not queued. rng_place_done outside WAIT is ignored.
- rng_mult/rng_incr/rng_n_mines are stable from CONFIG through CHECK of each attempt.

## Timing
- new_game sampled at edge 0 → CONFIG in cycle 1, rng_start high in cycle 2, WAIT from cycle 3.
- place_done seen in WAIT cycle N → CHECK N+1 → board_valid high from cycle N+2.
- Timeout attempt: TIMEOUT+1 WAIT cycles, then CHECK, then CONFIG. Each retry costs 3 + WAIT cycles.
- busy rises the cycle after new_game is accepted. It falls together with board_valid or error rising.
- restart asserted in any cycle: outputs clear immediately (asynchronous), state IDLE; release takes effect at the next clka edge.

## Test plan
- difficulty=2, seed=1, RNG model returns 5 distinct mines 4 cycles after start → exactly one rng_start pulse, rng_mult=1, rng_incr=1, rng_n_mines=5; board_valid at place_done+2; mine_count=5; retries=0.
- difficulty=1, first map has 2 bits (collision), second has 3 → second attempt rng_mult=seed+1, rng_incr=3; retries=1; board equals the second map; board_valid=1.
- RNG never asserts place_done, TIMEOUT=31 → each attempt waits 32 cycles; after 8 attempts error=1, busy=0, retries=7, board_valid=0.
- seed=7 with retries → rng_mult sequence 7,0,1,… (3-bit wrap); rng_incr 1,3,5,7,1,…
- restart pulsed mid-WAIT → all outputs 0 asynchronously; a later place_done is ignored; state stays IDLE until new_game.
- new_game held during busy → ignored. new_game in DONE → board_valid low next cycle, retries=0, new rng_start 2 cycles later. place_done in the same cycle as timeout → treated as completion.

Source files
------------

// File: rtl/mine_place_ctrl_if.sv
// mine_place_ctrl_if
//   Connection between the placement sequencer and the mine-placement RNG.
//
//   Handshake: the sequencer drives rng_mult, rng_incr and rng_n_mines, holds
//   them stable, and then raises rng_start for exactly one clock. The RNG works
//   for any number of cycles and raises rng_place_done. rng_mines is only
//   meaningful in a cycle where rng_place_done is 1. The sequencer accepts
//   rng_place_done only while it is waiting for a result. If no result arrives
//   it abandons the attempt, so the RNG never sees back-pressure.
//
//   Signals
//     rng_start       ctrl -> rng  one-cycle start pulse
//     rng_mult        ctrl -> rng  LCG multiplier 'a'
//     rng_incr        ctrl -> rng  LCG increment 'c' (always odd)
//     rng_n_mines     ctrl -> rng  number of mines to place
//     rng_place_done  rng -> ctrl  result available this cycle
//     rng_mines       rng -> ctrl  25-cell mine map
interface mine_place_ctrl_if;
   logic        rng_start;
   logic [2:0]  rng_mult;
   logic [2:0]  rng_incr;
   logic [2:0]  rng_n_mines;
   logic        rng_place_done;
   logic [24:0] rng_mines;

   modport master (
      output rng_start,
      output rng_mult,
      output rng_incr,
      output rng_n_mines,
      input  rng_place_done,
      input  rng_mines
   );

   modport slave (
      input  rng_start,
      input  rng_mult,
      input  rng_incr,
      input  rng_n_mines,
      output rng_place_done,
      output rng_mines
   );
endinterface

// File: rtl/mine_place_ctrl.sv
// mine_place_ctrl
//   Sequencer that runs the mine-placement RNG for a new game. It configures
//   the LCG and pulses start, then waits for place-done under a timeout. It
//   checks that the returned map holds exactly the requested number of mines.
//   On success it publishes the map. On failure it retries with new LCG
//   parameters until the retry limit is reached.
//
//   Parameters
//     TIMEOUT    last timer value allowed in WAIT (WAIT lasts TIMEOUT+1 cycles)
//     MAX_RETRY  retries allowed after the first attempt
//
//   Ports
//     clka         system clock, rising edge
//     restart      asynchronous active-high reset
//     new_game     start a placement; honoured only in IDLE, DONE and FAIL
//     difficulty   mine count select: 0->2, 1->3, 2->5, 3->7
//     seed         base LCG multiplier for the first attempt
//     rng          RNG connection (master side)
//     board        last accepted mine map
//     mine_count   mines in board
//     board_valid  board accepted and stable (DONE)
//     busy         placement in progress (CONFIG..CHECK)
//     error        every attempt failed (FAIL)
//     retries      retries consumed by the current or last request
//     state_dbg    current FSM state encoding, for observation only
module mine_place_ctrl #(
   parameter int TIMEOUT   = 31,
   parameter int MAX_RETRY = 7
) (
   input  logic              clka,
   input  logic              restart,
   input  logic              new_game,
   input  logic [1:0]        difficulty,
   input  logic [2:0]        seed,
   mine_place_ctrl_if.master rng,
   output logic [24:0]       board,
   output logic [2:0]        mine_count,
   output logic              board_valid,
   output logic              busy,
   output logic              error,
   output logic [2:0]        retries,
   output logic [2:0]        state_dbg
);

   localparam logic [4:0] TIMEOUT_V   = TIMEOUT[4:0];
   localparam logic [2:0] MAX_RETRY_V = MAX_RETRY[2:0];

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_CONFIG = 3'd1,
      S_START  = 3'd2,
      S_WAIT   = 3'd3,
      S_CHECK  = 3'd4,
      S_DONE   = 3'd5,
      S_FAIL   = 3'd6
   } state_t;

   state_t      state;
   state_t      state_nxt;

   logic [4:0]  timer;
   logic [24:0] staging;
   logic        timed_out;

   // Single-cycle control strobes from the next-state logic to the datapath.
   logic        do_accept;
   logic        do_retry;
   logic        do_commit;
   logic        do_capture;
   logic        do_timeout;
   logic        tmr_clr;
   logic        tmr_inc;

   logic [4:0]  staging_pop;
   logic        count_ok;
   logic [2:0]  retries_nxt;

   function automatic logic [4:0] popcount25(input logic [24:0] v);
      logic [4:0] c;
      c = 5'd0;
      for (int i = 0; i < 25; i++) begin
         c = c + {4'd0, v[i]};
      end
      return c;
   endfunction

   function automatic logic [2:0] mines_for(input logic [1:0] d);
      logic [2:0] m;
      case (d)
         2'd0:    m = 3'd2;
         2'd1:    m = 3'd3;
         2'd2:    m = 3'd5;
         default: m = 3'd7;
      endcase
      return m;
   endfunction

   assign staging_pop = popcount25(staging);
   // A timed-out attempt never counts, whatever the staging register holds.
   assign count_ok    = !timed_out && (staging_pop == {2'b00, rng.rng_n_mines});
   assign retries_nxt = retries + 3'd1;
   assign state_dbg   = state;

   // State register.
   always_ff @(posedge clka or posedge restart) begin
      if (restart) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state, control strobes and state-decoded outputs.
   always_comb begin
      state_nxt     = state;
      do_accept     = 1'b0;
      do_retry      = 1'b0;
      do_commit     = 1'b0;
      do_capture    = 1'b0;
      do_timeout    = 1'b0;
      tmr_clr       = 1'b0;
      tmr_inc       = 1'b0;
      rng.rng_start = 1'b0;
      busy          = 1'b0;
      board_valid   = 1'b0;
      error         = 1'b0;

      case (state)
         S_IDLE, S_DONE, S_FAIL: begin
            board_valid = (state == S_DONE);
            error       = (state == S_FAIL);
            if (new_game) begin
               do_accept = 1'b1;
               state_nxt = S_CONFIG;
            end
         end
         S_CONFIG: begin
            busy      = 1'b1;
            state_nxt = S_START;
         end
         S_START: begin
            busy          = 1'b1;
            rng.rng_start = 1'b1;
            tmr_clr       = 1'b1;
            state_nxt     = S_WAIT;
         end
         S_WAIT: begin
            busy = 1'b1;
            // A result arriving on the last timer cycle still counts.
            if (rng.rng_place_done) begin
               do_capture = 1'b1;
               state_nxt  = S_CHECK;
            end else if (timer == TIMEOUT_V) begin
               do_timeout = 1'b1;
               state_nxt  = S_CHECK;
            end else begin
               tmr_inc = 1'b1;
            end
         end
         S_CHECK: begin
            busy = 1'b1;
            if (count_ok) begin
               do_commit = 1'b1;
               state_nxt = S_DONE;
            end else if (retries < MAX_RETRY_V) begin
               do_retry  = 1'b1;
               state_nxt = S_CONFIG;
            end else begin
               state_nxt = S_FAIL;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Datapath. The LCG parameters are loaded on the edge that enters CONFIG.
   // That keeps them stable from CONFIG through CHECK of each attempt.
   // 2*r+1 modulo 8 is simply {r[1:0], 1}.
   always_ff @(posedge clka or posedge restart) begin
      if (restart) begin
         rng.rng_mult    <= 3'd0;
         rng.rng_incr    <= 3'd0;
         rng.rng_n_mines <= 3'd0;
         retries         <= 3'd0;
         timer           <= 5'd0;
         staging         <= 25'd0;
         timed_out       <= 1'b0;
         board           <= 25'd0;
         mine_count      <= 3'd0;
      end else begin
         if (do_accept) begin
            rng.rng_n_mines <= mines_for(difficulty);
            retries         <= 3'd0;
            rng.rng_mult    <= seed;
            rng.rng_incr    <= 3'd1;
         end
         if (do_retry) begin
            retries      <= retries_nxt;
            rng.rng_mult <= seed + retries_nxt;
            rng.rng_incr <= {retries_nxt[1:0], 1'b1};
         end
         if (tmr_clr) begin
            timer <= 5'd0;
         end else if (tmr_inc) begin
            timer <= timer + 5'd1;
         end
         if (do_capture) begin
            staging   <= rng.rng_mines;
            timed_out <= 1'b0;
         end
         if (do_timeout) begin
            timed_out <= 1'b1;
         end
         if (do_commit) begin
            board      <= staging;
            mine_count <= rng.rng_n_mines;
         end
      end
   end

endmodule

// File: tb/tb_mine_place_ctrl.sv
// tb_mine_place_ctrl
//   Bench for mine_place_ctrl. The RNG side is scripted per request: each
//   attempt either times out, returns a map with the wrong mine count, or
//   returns a good map after a chosen latency. The expected LCG parameters per
//   attempt are queued up front from the arithmetic rules. The final outcome
//   comes from the number of bad attempts, and the cycle of every start pulse
//   comes from the documented latencies.
module tb_mine_place_ctrl;

   // ---------------- clock / reset ----------------
   logic clka = 1'b0;
   always #5 clka = ~clka;

   logic        restart;
   logic        new_game;
   logic [1:0]  difficulty;
   logic [2:0]  seed;
   logic [24:0] board;
   logic [2:0]  mine_count;
   logic        board_valid;
   logic        busy;
   logic        error;
   logic [2:0]  retries;
   logic [2:0]  state_dbg;

   mine_place_ctrl_if rif();

   mine_place_ctrl #(.TIMEOUT(31), .MAX_RETRY(7)) dut (
      .clka        (clka),
      .restart     (restart),
      .new_game    (new_game),
      .difficulty  (difficulty),
      .seed        (seed),
      .rng         (rif),
      .board       (board),
      .mine_count  (mine_count),
      .board_valid (board_valid),
      .busy        (busy),
      .error       (error),
      .retries     (retries),
      .state_dbg   (state_dbg)
   );

   // ---------------- bookkeeping ----------------
   int          n_tests = 0;
   int          n_fail  = 0;
   int          cyc     = 0;
   int          start_cnt = 0;
   logic [24:0] prev_board;
   logic [2:0]  prev_mc;
   logic [31:0] exp_q[$];

   always @(posedge clka) begin
      if (rif.rng_start === 1'b1) start_cnt++;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [1:0] diff;
      logic [2:0] seed;
      int         n_bad;
      bit         bad_to;
      int         lat;
      logic [2:0] exp_ret;
      bit         exp_err;
      logic [2:0] exp_nm;
   } vec_t;

   vec_t vecs[8];

   // ---------------- helpers ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step();
      @(negedge clka);
      cyc++;
   endtask

   function automatic logic [2:0] mines_for(input logic [1:0] d);
      case (d)
         2'd0:    return 3'd2;
         2'd1:    return 3'd3;
         2'd2:    return 3'd5;
         default: return 3'd7;
      endcase
   endfunction

   function automatic logic [24:0] mk_map(input int k);
      logic [24:0] m;
      int          cnt;
      int          p;
      m   = '0;
      cnt = 0;
      while (cnt < k) begin
         p = $urandom_range(0, 24);
         if (!m[p]) begin
            m[p] = 1'b1;
            cnt++;
         end
      end
      return m;
   endfunction

   // ---------------- driver + checker for one request ----------------
   // n_bad >= 8 means every attempt is bad. Bad attempts are timeouts if
   // bad_to, otherwise maps with a wrong mine count returned after lat cycles.
   task automatic run_req(input logic [1:0] diff, input logic [2:0] sd, input int n_bad,
                          input bit bad_to, input int lat, input logic [2:0] exp_ret,
                          input bit exp_err, input logic [2:0] exp_nm);
      int          n_att;
      int          exp_start;
      int          s;
      int          chk_cyc;
      int          base;
      int          g;
      int          nm;
      logic [24:0] good;
      logic [24:0] badm;
      logic [31:0] e;
      bit          bad;

      nm    = int'(mines_for(diff));
      n_att = (n_bad >= 8) ? 8 : n_bad + 1;
      exp_q.delete();
      for (int k = 0; k < n_att; k++) begin
         exp_q.push_back(32'((nm << 6) | (((int'(sd) + k) % 8) << 3) | ((2 * k + 1) % 8)));
      end
      good = mk_map(nm);

      base       = start_cnt;
      difficulty = diff;
      seed       = sd;
      new_game   = 1'b1;
      step();
      new_game   = 1'b0;
      chk("cfg_busy", 32'(busy), 32'd1);
      chk("cfg_board_valid", 32'(board_valid), 32'd0);
      chk("cfg_error", 32'(error), 32'd0);
      chk("cfg_retries", 32'(retries), 32'd0);
      exp_start = cyc + 1;
      chk_cyc   = cyc;

      for (int k = 0; k < n_att; k++) begin
         g = 0;
         step();
         while (rif.rng_start !== 1'b1 && g < 40) begin
            step();
            g++;
         end
         if (rif.rng_start !== 1'b1) begin
            chk("start_seen", 32'd0, 32'd1);
            return;
         end
         chk("start_cycle", 32'(cyc), 32'(exp_start));
         e = exp_q.pop_front();
         chk("rng_params", {23'd0, rif.rng_n_mines, rif.rng_mult, rif.rng_incr}, e);
         s   = cyc;
         bad = (k < n_bad);
         if (bad && bad_to) begin
            chk_cyc   = s + 33;
            exp_start = s + 35;
         end else begin
            badm = mk_map(($urandom_range(0, 1) == 0) ? nm - 1 : nm + 1);
            repeat (lat) step();
            chk("params_stable", {23'd0, rif.rng_n_mines, rif.rng_mult, rif.rng_incr}, e);
            rif.rng_place_done = 1'b1;
            rif.rng_mines      = bad ? badm : good;
            step();
            rif.rng_place_done = 1'b0;
            rif.rng_mines      = 25'($urandom);
            chk("check_busy", 32'(busy), 32'd1);
            chk("check_board_valid", 32'(board_valid), 32'd0);
            chk_cyc   = cyc;
            exp_start = cyc + 2;
         end
      end

      g = 0;
      while (cyc < chk_cyc + 1 && g < 40) begin
         step();
         g++;
      end
      chk("final_retries", 32'(retries), 32'(exp_ret));
      chk("final_busy", 32'(busy), 32'd0);
      chk("start_pulses", 32'(start_cnt - base), 32'(n_att));
      if (exp_err) begin
         chk("fail_error", 32'(error), 32'd1);
         chk("fail_board_valid", 32'(board_valid), 32'd0);
         chk("fail_board_kept", 32'(board), 32'(prev_board));
         chk("fail_count_kept", 32'(mine_count), 32'(prev_mc));
      end else begin
         chk("ok_board_valid", 32'(board_valid), 32'd1);
         chk("ok_error", 32'(error), 32'd0);
         chk("ok_board", 32'(board), 32'(good));
         chk("ok_mine_count", 32'(mine_count), 32'(exp_nm));
         prev_board = good;
         prev_mc    = exp_nm;
         step();
         chk("ok_held", 32'(board_valid), 32'd1);
      end
   endtask

   // ---------------- main sequence ----------------
   initial begin
      restart            = 1'b1;
      new_game           = 1'b0;
      difficulty         = 2'd0;
      seed               = 3'd0;
      rif.rng_place_done = 1'b0;
      rif.rng_mines      = 25'd0;
      prev_board         = 25'd0;
      prev_mc            = 3'd0;

      step();
      step();
      chk("rst_outputs", {board, mine_count, board_valid, busy, error, retries},
          32'd0);
      chk("rst_rng", {23'd0, rif.rng_start, rif.rng_mult, rif.rng_incr, rif.rng_n_mines}, 32'd0);
      restart = 1'b0;
      step();
      chk("idle_busy", 32'(busy), 32'd0);

      // diff, seed, n_bad, bad_to, lat, exp_ret, exp_err, exp_nm
      vecs[0] = '{2'd2, 3'd1, 0, 1'b0,  4, 3'd0, 1'b0, 3'd5};
      vecs[1] = '{2'd1, 3'd5, 1, 1'b0,  2, 3'd1, 1'b0, 3'd3};
      vecs[2] = '{2'd0, 3'd0, 8, 1'b1,  1, 3'd7, 1'b1, 3'd2};
      vecs[3] = '{2'd3, 3'd7, 3, 1'b0,  1, 3'd3, 1'b0, 3'd7};
      vecs[4] = '{2'd0, 3'd3, 0, 1'b0, 32, 3'd0, 1'b0, 3'd2};
      vecs[5] = '{2'd2, 3'd6, 8, 1'b0,  5, 3'd7, 1'b1, 3'd5};
      vecs[6] = '{2'd1, 3'd2, 2, 1'b1,  6, 3'd2, 1'b0, 3'd3};
      vecs[7] = '{2'd3, 3'd4, 5, 1'b0, 32, 3'd5, 1'b0, 3'd7};
      foreach (vecs[i]) begin
         run_req(vecs[i].diff, vecs[i].seed, vecs[i].n_bad, vecs[i].bad_to, vecs[i].lat,
                 vecs[i].exp_ret, vecs[i].exp_err, vecs[i].exp_nm);
      end

      // new_game held high while busy: only one placement may start
      begin
         int          base;
         logic [24:0] m;
         base       = start_cnt;
         m          = mk_map(2);
         difficulty = 2'd0;
         seed       = 3'd2;
         new_game   = 1'b1;
         step();
         step();
         step();
         step();
         rif.rng_place_done = 1'b1;
         rif.rng_mines      = m;
         step();
         rif.rng_place_done = 1'b0;
         new_game           = 1'b0;
         step();
         chk("hold_board_valid", 32'(board_valid), 32'd1);
         chk("hold_starts", 32'(start_cnt - base), 32'd1);
         chk("hold_board", 32'(board), 32'(m));
         chk("hold_retries", 32'(retries), 32'd0);
         prev_board = m;
         prev_mc    = 3'd2;
      end

      // restart in the middle of WAIT; a late place_done must be ignored
      begin
         int base;
         base       = start_cnt;
         difficulty = 2'd1;
         seed       = 3'd3;
         new_game   = 1'b1;
         step();
         new_game   = 1'b0;
         step();
         step();
         step();
         #2 restart = 1'b1;
         #1;
         chk("async_outputs", {board, mine_count, board_valid, busy, error, retries},
             32'd0);
         chk("async_rng", {23'd0, rif.rng_start, rif.rng_mult, rif.rng_incr, rif.rng_n_mines},
             32'd0);
         step();
         restart            = 1'b0;
         rif.rng_place_done = 1'b1;
         rif.rng_mines      = mk_map(3);
         step();
         step();
         step();
         rif.rng_place_done = 1'b0;
         chk("rst_idle_busy", 32'(busy), 32'd0);
         chk("rst_idle_valid", 32'(board_valid), 32'd0);
         chk("rst_idle_board", 32'(board), 32'd0);
         chk("rst_idle_starts", 32'(start_cnt - base), 32'd1);
         prev_board = 25'd0;
         prev_mc    = 3'd0;
      end

      // randomized requests against the outcome model
      for (int r = 0; r < 15; r++) begin
         logic [1:0] d;
         logic [2:0] sd;
         int         nb;
         bit         bt;
         int         lt;
         d  = 2'($urandom_range(0, 3));
         sd = 3'($urandom_range(0, 7));
         nb = $urandom_range(0, 9);
         bt = 1'($urandom_range(0, 1));
         lt = $urandom_range(1, 32);
         run_req(d, sd, nb, bt, lt, 3'((nb > 7) ? 7 : nb), (nb >= 8), mines_for(d));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
